// File: rtl/instr_fetch_mem.sv
// RAM-backed instruction store for the fetch stage: program load port plus a
// req/ready fetch handshake with RD_LAT wait cycles. Define IMEM_BOUNDS_CHECK_EN for fault checking.
module instr_fetch_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 64,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [ADDR_W-1:0] address,
    output logic              ready,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              fault,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(RD_LAT + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  addr_q;
    logic               accept;
    logic               done;
    logic [IDX_W-1:0]   fetch_idx;
    logic [IDX_W-1:0]   ld_idx;
    logic               fetch_bad;
    logic               ld_bad;
    logic [DATA_W-1:0]  mem [DEPTH];

    assign fetch_idx = addr_q[IDX_W+1:2];
    assign ld_idx    = ld_addr[IDX_W+1:2];

`ifdef IMEM_BOUNDS_CHECK_EN
    assign fetch_bad = (addr_q[1:0] != 2'b00) || (|addr_q[ADDR_W-1:IDX_W+2]);
    assign ld_bad    = (ld_addr[1:0] != 2'b00) || (|ld_addr[ADDR_W-1:IDX_W+2]);
`else
    // Byte offset and upper bits are don't-care: indices wrap modulo DEPTH.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_q[1:0], addr_q[ADDR_W-1:IDX_W+2],
                                ld_addr[1:0], ld_addr[ADDR_W-1:IDX_W+2]};
    assign fetch_bad = 1'b0;
    assign ld_bad    = 1'b0;
`endif

    // Control FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    accept  = 1'b1;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    done    = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign ready = (state == S_IDLE);

    // Wait counter and registered fetch outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
        end else begin
            instr_valid <= done;
            fault       <= done && fetch_bad;
            if (accept) begin
                cnt <= CNT_W'(RD_LAT - 1);
            end else if (state == S_WAIT && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            // Non-blocking read returns pre-edge contents on a same-edge load.
            if (done) begin
                instr <= fetch_bad ? '0 : mem[fetch_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= address;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_en && !ld_bad) begin
            mem[ld_idx] <= ld_data;
        end
    end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench for instr_fetch_mem with a cycle-level reference model and literal checks.
// Honours IMEM_BOUNDS_CHECK_EN for the bounds-check scenario.
module tb_instr_fetch_mem;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 64;
    localparam int RD_LAT = 2;

    logic              clk;
    logic              reset;
    logic              req;
    logic [ADDR_W-1:0] address;
    logic              ready;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              fault;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_mem #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .address(address), .ready(ready),
        .instr(instr), .instr_valid(instr_valid), .fault(fault),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a fetch started at cycle c completes at cycle c+RD_LAT
    logic [DATA_W-1:0] mmem [DEPTH];
    logic              m_live = 1'b0;
    logic              m_pending;
    int                m_due;
    int                cyc;
    logic [ADDR_W-1:0] m_paddr;
    logic              m_ready, m_valid, m_fault;
    logic [DATA_W-1:0] m_instr;

    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
`ifdef IMEM_BOUNDS_CHECK_EN
        return (a % 4 != 0) || ((a / 4) >= DEPTH);
`else
        return (a == '1) && 1'b0;
`endif
    endfunction

    function automatic int addr_word(input logic [ADDR_W-1:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_live    = 1'b1;
            m_pending = 1'b0;
            m_ready   = 1'b1;
            m_valid   = 1'b0;
            m_fault   = 1'b0;
            m_instr   = '0;
            cyc       = 0;
        end else if (m_live) begin
            m_valid = 1'b0;
            m_fault = 1'b0;
            if (m_pending) begin
                if (cyc == m_due) begin
                    m_pending = 1'b0;
                    m_valid   = 1'b1;
                    m_fault   = addr_bad(m_paddr);
                    m_instr   = m_fault ? '0 : mmem[addr_word(m_paddr)];
                end
            end else if (req) begin
                m_pending = 1'b1;
                m_due     = cyc + RD_LAT;
                m_paddr   = address;
            end
            if (ld_en && !addr_bad(ld_addr)) mmem[addr_word(ld_addr)] = ld_data;
            m_ready = !m_pending;
            cyc++;
        end
        #1;
        if (m_live) begin
            check("model_ready", ready, m_ready);
            check("model_instr_valid", instr_valid, m_valid);
            check("model_fault", fault, m_fault);
            check("model_instr", instr, m_instr);
        end
    end

    task automatic load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Caller sits at a negedge with ready high; returns in the instr_valid cycle.
    task automatic fetch(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d, output logic f);
        int n;
        req = 1'b1; address = a;
        @(negedge clk);
        req = 1'b0;
        n = 0;
        while (!instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_valid) check("fetch_timeout", instr_valid, 1);
        d = instr;
        f = fault;
    endtask

    logic [DATA_W-1:0] rd;
    logic              rf;
    int                pulses, last_pulse, gap_bad;

    initial begin
        reset = 1'b1; req = 1'b0; address = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (2) @(negedge clk);
        check("reset_ready", ready, 1);
        check("reset_valid", instr_valid, 0);
        check("reset_fault", fault, 0);
        check("reset_instr", instr, 0);
        reset = 1'b0;
        @(negedge clk);

        load(32'h0, 32'h5800_0000);
        load(32'h4, 32'h5808_0010);
        load(32'h8, 32'h1111_1111);

        // First fetch, then back-to-back request in the valid cycle
        req = 1'b1; address = 32'h0;
        @(negedge clk);
        req = 1'b0;
        check("accept_ready_low", ready, 0);
        @(negedge clk);
        check("wait_valid_low", instr_valid, 0);
        @(negedge clk);
        check("fetch0_valid", instr_valid, 1);
        check("fetch0_instr", instr, 32'h5800_0000);
        check("fetch0_ready", ready, 1);
        req = 1'b1; address = 32'h4;
        @(negedge clk);
        req = 1'b0;
        check("b2b_accepted", ready, 0);
        check("hold_valid_low", instr_valid, 0);
        check("hold_instr", instr, 32'h5800_0000);
        @(negedge clk);
        check("b2b_gap_valid_low", instr_valid, 0);
        @(negedge clk);
        check("fetch4_valid", instr_valid, 1);
        check("fetch4_instr", instr, 32'h5808_0010);

        // Same-edge load on completion returns old data
        req = 1'b1; address = 32'h8;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 32'h8; ld_data = 32'h2000_0001;
        @(negedge clk);
        ld_en = 1'b0;
        check("collide_valid", instr_valid, 1);
        check("collide_old", instr, 32'h1111_1111);
        fetch(32'h8, rd, rf);
        check("after_collide_new", rd, 32'h2000_0001);

`ifdef IMEM_BOUNDS_CHECK_EN
        fetch(32'h102, rd, rf);
        check("misaligned_fault", rf, 1);
        check("misaligned_instr", rd, 0);
        fetch(32'h100, rd, rf);
        check("oob_fault", rf, 1);
        check("oob_instr", rd, 0);
        load(32'h100, 32'hDEAD_BEEF);
        fetch(32'h0, rd, rf);
        check("oob_load_dropped", rd, 32'h5800_0000);
        check("word0_fault", rf, 0);
`else
        fetch(32'h100, rd, rf);
        check("wrap_instr", rd, 32'h5800_0000);
        check("wrap_fault", rf, 0);
`endif

        // Reset one cycle after acceptance aborts the fetch
        req = 1'b1; address = 32'h4;
        @(negedge clk);
        req = 1'b0;
        reset = 1'b1;
        #1;
        check("abort_ready_now", ready, 1);
        check("abort_valid_now", instr_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (instr_valid) pulses++;
        end
        check("abort_no_valid", pulses, 0);
        fetch(32'h4, rd, rf);
        check("post_reset_instr", rd, 32'h5808_0010);
        check("post_reset_fault", rf, 0);

        // Sustained requests: one completion every RD_LAT+1 cycles
        @(negedge clk);
        req = 1'b1; address = 32'h0;
        pulses = 0; last_pulse = -1; gap_bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                if (last_pulse >= 0 && i - last_pulse != RD_LAT + 1) gap_bad++;
                last_pulse = i;
                pulses++;
            end
        end
        req = 1'b0;
        check("stream_pulses", pulses, 10);
        check("stream_gap_errors", gap_bad, 0);
        check("stream_last_pulse", last_pulse, 29);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
